// File: rtl/alu_seq.sv
// alu_seq -- sequenced 16-bit ALU stage sitting directly below the data stack.
//
// On Start (accepted only while Busy=0), the opcode and the stack's T/N outputs
// are consumed. Simple ALU ops produce their write-back in the next cycle.
// MUL and DIVMOD iterate bit-serially for 16 cycles. DIVMOD then writes back
// two words on consecutive cycles through the single stack data port.
//
// Ports:
//   Clk     in   1   clock, rising edge
//   Rst     in   1   synchronous active-high reset
//   Start   in   1   command strobe (ignored while Busy)
//   Op      in   4   opcode, sampled with Start
//   T, N    in  16   stack top / second, sampled with Start
//   TWrite  out  1   write WData to the new top slot
//   NWrite  out  1   write WData to the new second slot
//   WData   out 16   write-back data
//   Offset  out  2   stack-pointer change: 01=+1, 00=0, 11=-1
//   Busy    out  1   high whenever the FSM is not idle
//   Done    out  1   pulse on the final write-back cycle of a command
//   Illegal out  1   pulse with Done for an undefined opcode (11..15)
module alu_seq (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [15:0] T,
  input  logic [15:0] N,
  output logic        TWrite,
  output logic        NWrite,
  output logic [15:0] WData,
  output logic [1:0]  Offset,
  output logic        Busy,
  output logic        Done,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    MUL_IT = 3'd2,
    MUL_WB = 3'd3,
    DIV_IT = 3'd4,
    DIV_WN = 3'd5,
    DIV_WT = 3'd6
  } state_t;

  localparam logic [3:0] OP_MUL    = 4'd9;
  localparam logic [3:0] OP_DIVMOD = 4'd10;
  localparam logic [1:0] OFF_POP   = 2'b11;
  localparam logic [1:0] OFF_KEEP  = 2'b00;

  state_t      r_state;
  logic [3:0]  r_cnt;
  // r_a: multiplicand (MUL) or divisor (DIVMOD).
  // r_b: multiplier (MUL) or dividend shifting out / quotient shifting in (DIVMOD).
  // r_acc: product accumulator (MUL) or partial remainder (DIVMOD).
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_acc;

  logic        r_twrite;
  logic        r_nwrite;
  logic [15:0] r_wdata;
  logic [1:0]  r_offset;
  logic        r_busy;
  logic        r_done;
  logic        r_illegal;

  // Single-cycle ALU result, computed straight from the stack inputs so the
  // write-back register can be loaded on the same edge that accepts Start.
  logic [15:0] w_alu_res;
  logic        w_alu_legal;
  logic        w_alu_pop;

  always_comb begin
    w_alu_res   = 16'h0000;
    w_alu_legal = 1'b1;
    w_alu_pop   = 1'b1;
    case (Op)
      4'd0: w_alu_res = N + T;
      4'd1: w_alu_res = N - T;
      4'd2: w_alu_res = N & T;
      4'd3: w_alu_res = N | T;
      4'd4: w_alu_res = N ^ T;
      4'd5: begin
        w_alu_res = ~T;
        w_alu_pop = 1'b0;
      end
      4'd6: w_alu_res = ($signed(N) < $signed(T)) ? 16'hFFFF : 16'h0000;
      4'd7: w_alu_res = N << T[3:0];
      4'd8: w_alu_res = N >> T[3:0];
      default: begin
        w_alu_legal = 1'b0;
        w_alu_pop   = 1'b0;
      end
    endcase
  end

  // Shift-add multiply step: add the multiplicand when the current multiplier
  // LSB is set. The 16th step's sum is the final product.
  logic [15:0] w_mul_acc;
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : 16'h0000);

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Bit 16 of the difference is
  // the borrow. A zero divisor always "fits", which naturally yields
  // quotient FFFF and remainder N.
  logic [16:0] w_div_trial;
  logic [16:0] w_div_diff;
  logic        w_div_ge;
  logic [15:0] w_div_rem;
  logic [15:0] w_div_quo;

  assign w_div_trial = {r_acc, r_b[15]};
  assign w_div_diff  = w_div_trial - {1'b0, r_a};
  assign w_div_ge    = ~w_div_diff[16];
  assign w_div_rem   = w_div_ge ? w_div_diff[15:0] : w_div_trial[15:0];
  assign w_div_quo   = {r_b[14:0], w_div_ge};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_a       <= 16'h0000;
      r_b       <= 16'h0000;
      r_acc     <= 16'h0000;
      r_twrite  <= 1'b0;
      r_nwrite  <= 1'b0;
      r_wdata   <= 16'h0000;
      r_offset  <= OFF_KEEP;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // Write-back outputs are pulses: cleared unless a state below loads them.
      r_twrite  <= 1'b0;
      r_nwrite  <= 1'b0;
      r_wdata   <= 16'h0000;
      r_offset  <= OFF_KEEP;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;

      case (r_state)
        IDLE: begin
          if (Start) begin
            r_busy <= 1'b1;
            r_cnt  <= 4'd0;
            r_acc  <= 16'h0000;
            if (Op == OP_MUL) begin
              r_a     <= N;
              r_b     <= T;
              r_state <= MUL_IT;
            end else if (Op == OP_DIVMOD) begin
              r_a     <= T;
              r_b     <= N;
              r_state <= DIV_IT;
            end else begin
              r_a     <= N;
              r_b     <= T;
              r_state <= EXEC;
              r_done  <= 1'b1;
              if (w_alu_legal) begin
                r_twrite <= 1'b1;
                r_wdata  <= w_alu_res;
                r_offset <= w_alu_pop ? OFF_POP : OFF_KEEP;
              end else begin
                r_illegal <= 1'b1;
              end
            end
          end
        end

        EXEC: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        MUL_IT: begin
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state  <= MUL_WB;
            r_twrite <= 1'b1;
            r_wdata  <= w_mul_acc;
            r_offset <= OFF_POP;
            r_done   <= 1'b1;
          end
        end

        MUL_WB: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        DIV_IT: begin
          r_acc <= w_div_rem;
          r_b   <= w_div_quo;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state  <= DIV_WN;
            r_nwrite <= 1'b1;
            r_wdata  <= w_div_rem;
          end
        end

        DIV_WN: begin
          // r_b now holds the complete quotient.
          r_state  <= DIV_WT;
          r_twrite <= 1'b1;
          r_wdata  <= r_b;
          r_done   <= 1'b1;
        end

        DIV_WT: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TWrite  = r_twrite;
  assign NWrite  = r_nwrite;
  assign WData   = r_wdata;
  assign Offset  = r_offset;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: a behavioural model that schedules the expected
// write-back of each accepted command by edge number, compared against the
// DUT outputs on every falling edge, plus directed scenarios with literal
// expected values.
module tb_alu_seq;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [3:0]  Op;
  logic [15:0] T;
  logic [15:0] N;
  logic        TWrite;
  logic        NWrite;
  logic [15:0] WData;
  logic [1:0]  Offset;
  logic        Busy;
  logic        Done;
  logic        Illegal;

  alu_seq dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Start   (Start),
    .Op      (Op),
    .T       (T),
    .N       (N),
    .TWrite  (TWrite),
    .NWrite  (NWrite),
    .WData   (WData),
    .Offset  (Offset),
    .Busy    (Busy),
    .Done    (Done),
    .Illegal (Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        tw;
    logic        nw;
    logic [15:0] wd;
    logic [1:0]  off;
    logic        done;
    logic        ill;
  } wb_t;

  // Expected outputs keyed by the index of the rising edge after which they
  // are visible; absent entries mean an all-zero (idle) output set.
  wb_t exp_q [int];
  int  ecnt     = -1;
  int  busy_end = -100;
  int  total    = 0;
  int  bad      = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, ecnt, act, want);
    end
  endtask

  // Behavioural model: accepts a command when Busy was low during the cycle
  // that ends at this edge, and schedules its write-back(s).
  longint m_n, m_t, m_res, m_sn, m_st;
  wb_t    m_w, m_w2;

  always @(posedge Clk) begin
    ecnt = ecnt + 1;
    if (Rst) begin
      exp_q.delete();
      busy_end = -100;
    end else if (Start && ecnt > busy_end + 1) begin
      m_n = longint'(N);
      m_t = longint'(T);
      m_sn = (m_n >= 32768) ? m_n - 65536 : m_n;
      m_st = (m_t >= 32768) ? m_t - 65536 : m_t;
      m_w  = '0;
      m_w.done = 1'b1;
      $display("txn edge=%0d op=%0d n=%h t=%h", ecnt, Op, N, T);
      if (Op <= 4'd8) begin
        case (Op)
          4'd0: m_res = m_n + m_t;
          4'd1: m_res = m_n - m_t + 65536;
          4'd2: m_res = m_n & m_t;
          4'd3: m_res = m_n | m_t;
          4'd4: m_res = m_n ^ m_t;
          4'd5: m_res = 65535 - m_t;
          4'd6: m_res = (m_sn < m_st) ? 65535 : 0;
          4'd7: m_res = m_n << (m_t % 16);
          default: m_res = m_n >> (m_t % 16);
        endcase
        m_w.tw  = 1'b1;
        m_w.wd  = m_res[15:0];
        m_w.off = (Op == 4'd5) ? 2'b00 : 2'b11;
        exp_q[ecnt] = m_w;
        busy_end = ecnt;
      end else if (Op == 4'd9) begin
        m_res   = m_n * m_t;
        m_w.tw  = 1'b1;
        m_w.wd  = m_res[15:0];
        m_w.off = 2'b11;
        exp_q[ecnt + 16] = m_w;
        busy_end = ecnt + 16;
      end else if (Op == 4'd10) begin
        m_w2 = '0;
        m_w2.nw = 1'b1;
        if (m_t == 0) begin
          m_w2.wd = m_n[15:0];
          m_w.wd  = 16'hFFFF;
        end else begin
          m_res   = m_n % m_t;
          m_w2.wd = m_res[15:0];
          m_res   = m_n / m_t;
          m_w.wd  = m_res[15:0];
        end
        m_w.tw = 1'b1;
        exp_q[ecnt + 16] = m_w2;
        exp_q[ecnt + 17] = m_w;
        busy_end = ecnt + 17;
      end else begin
        m_w.ill = 1'b1;
        exp_q[ecnt] = m_w;
        busy_end = ecnt;
      end
    end
  end

  // Compare process: every cycle, all outputs against the model.
  wb_t c_w;
  always @(negedge Clk) begin
    if (ecnt >= 0) begin
      c_w = exp_q.exists(ecnt) ? exp_q[ecnt] : '0;
      chk("m_twrite",  {15'd0, TWrite},  {15'd0, c_w.tw});
      chk("m_nwrite",  {15'd0, NWrite},  {15'd0, c_w.nw});
      chk("m_wdata",   WData,            c_w.wd);
      chk("m_offset",  {14'd0, Offset},  {14'd0, c_w.off});
      chk("m_done",    {15'd0, Done},    {15'd0, c_w.done});
      chk("m_illegal", {15'd0, Illegal}, {15'd0, c_w.ill});
      chk("m_busy",    {15'd0, Busy},    {15'd0, (ecnt <= busy_end)});
    end
  end

  // Drive a command during one cycle; returns at the falling edge of the
  // cycle right after the sampling edge, with operands scrambled.
  task automatic cmd(input logic [3:0] op, input logic [15:0] n, input logic [15:0] t);
    Start = 1'b1;
    Op    = op;
    N     = n;
    T     = t;
    @(negedge Clk);
    Start = 1'b0;
    N     = 16'($urandom);
    T     = 16'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (Busy && i < 40) begin
      @(negedge Clk);
      i++;
    end
    if (Busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  initial begin
    Rst   = 1'b1;
    Start = 1'b0;
    Op    = 4'd0;
    T     = 16'h0000;
    N     = 16'h0000;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    // Reset then idle.
    repeat (5) begin
      @(negedge Clk);
      chk("idle_busy",  {15'd0, Busy},   16'd0);
      chk("idle_wdata", WData,           16'd0);
      chk("idle_done",  {15'd0, Done},   16'd0);
    end

    // ADD, including wrap.
    cmd(4'd0, 16'h7FFF, 16'h0001);
    chk("add_tw",   {15'd0, TWrite}, 16'd1);
    chk("add_wd",   WData,           16'h8000);
    chk("add_off",  {14'd0, Offset}, 16'd3);
    chk("add_done", {15'd0, Done},   16'd1);
    @(negedge Clk);
    wait_idle();
    cmd(4'd0, 16'hFFFF, 16'h0002);
    chk("add_wrap_wd", WData, 16'h0001);
    @(negedge Clk);
    wait_idle();

    // MUL with an ignored Start at k+5.
    cmd(4'd9, 16'h0123, 16'h0010);
    chk("mul_busy_k1", {15'd0, Busy}, 16'd1);
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    Op    = 4'd0;
    @(negedge Clk);
    Start = 1'b0;
    repeat (11) @(negedge Clk);
    chk("mul_tw",   {15'd0, TWrite}, 16'd1);
    chk("mul_wd",   WData,           16'h1230);
    chk("mul_off",  {14'd0, Offset}, 16'd3);
    chk("mul_busy", {15'd0, Busy},   16'd1);
    @(negedge Clk);
    chk("mul_after_busy", {15'd0, Busy},   16'd0);
    chk("mul_after_tw",   {15'd0, TWrite}, 16'd0);
    wait_idle();

    // DIVMOD 100/7, then divide by zero.
    cmd(4'd10, 16'd100, 16'd7);
    repeat (16) @(negedge Clk);
    chk("div_nw",  {15'd0, NWrite}, 16'd1);
    chk("div_rem", WData,           16'h0002);
    chk("div_off", {14'd0, Offset}, 16'd0);
    @(negedge Clk);
    chk("div_tw",   {15'd0, TWrite}, 16'd1);
    chk("div_quo",  WData,           16'h000E);
    chk("div_done", {15'd0, Done},   16'd1);
    @(negedge Clk);
    wait_idle();
    cmd(4'd10, 16'd100, 16'd0);
    repeat (16) @(negedge Clk);
    chk("div0_rem", WData, 16'h0064);
    @(negedge Clk);
    chk("div0_quo", WData, 16'hFFFF);
    @(negedge Clk);
    wait_idle();

    // LT, SHR, illegal opcode.
    cmd(4'd6, 16'hFFFE, 16'h0001);
    chk("lt_wd", WData, 16'hFFFF);
    @(negedge Clk);
    cmd(4'd8, 16'h8000, 16'h0013);
    chk("shr_wd", WData, 16'h1000);
    @(negedge Clk);
    cmd(4'd12, 16'h1234, 16'h5678);
    chk("ill_done", {15'd0, Done},    16'd1);
    chk("ill_ill",  {15'd0, Illegal}, 16'd1);
    chk("ill_tw",   {15'd0, TWrite},  16'd0);
    chk("ill_nw",   {15'd0, NWrite},  16'd0);
    @(negedge Clk);

    // Reset in the middle of DIVMOD.
    cmd(4'd10, 16'd5000, 16'd3);
    repeat (8) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_busy", {15'd0, Busy}, 16'd0);
    repeat (20) begin
      @(negedge Clk);
      chk("rst_no_wr", {14'd0, TWrite, NWrite}, 16'd0);
    end
    cmd(4'd0, 16'h0003, 16'h0004);
    chk("post_rst_add", WData, 16'h0007);
    @(negedge Clk);

    // Randomized traffic, including Starts while busy and rare resets.
    for (int i = 0; i < 2000; i++) begin
      Start = ($urandom_range(0, 2) == 0);
      Op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 10)) : 4'($urandom);
      N     = 16'($urandom);
      T     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) N = 16'h8000;
      Rst   = ($urandom_range(0, 499) == 0);
      @(negedge Clk);
    end
    Start = 1'b0;
    Rst   = 1'b0;
    repeat (40) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
